alu_result_stage: RTL and testbench

Registered result/flag stage directly downstream of the 32-bit combinational ALU. It captures the ALU's result, carryout, zero and overflow with the issuing command through a valid/ready handshake into a 2-entry FIFO, and derives a negative flag. It presents the entries to the writeback consumer in order and keeps sticky carry/overflow status plus a saturating overflow event counter for software.

---
 rtl/alu_result_stage_if.sv | 42 ++++
 rtl/alu_result_stage.sv | 138 +++++++++++++
 tb/tb_alu_result_stage.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: handshake and status bundle between the ALU, the result
// stage and the writeback consumer.
//   in_*           ALU side: valid/ready push of result, flags and command
//   out_*          consumer side: valid/ready pop of head entry, flags {N,Z,C,V}
//   sticky_*       sticky carry/overflow status and its single-cycle clear
//   ovf_count      saturating count of accepted entries with overflow
// Modport slave is the stage itself; master is the surrounding logic.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carryout;
    logic             in_zero;
    logic             in_overflow;
    logic [2:0]       in_command;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [2:0]       out_command;
    logic             sticky_carry;
    logic             sticky_ovf;
    logic             sticky_clear;
    logic [CNT_W-1:0] ovf_count;

    modport slave (
        input  in_valid, in_result, in_carryout, in_zero, in_overflow, in_command,
        input  out_ready, sticky_clear,
        output in_ready, out_valid, out_result, out_flags, out_command,
        output sticky_carry, sticky_ovf, ovf_count
    );

    modport master (
        output in_valid, in_result, in_carryout, in_zero, in_overflow, in_command,
        output out_ready, sticky_clear,
        input  in_ready, out_valid, out_result, out_flags, out_command,
        input  sticky_carry, sticky_ovf, ovf_count
    );
endinterface

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result/flag stage behind the 32-bit ALU.
// Captures result, flags and command into a 2-entry in-order FIFO, derives the
// negative flag, and keeps sticky carry/overflow bits plus a saturating
// overflow event counter.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_result_stage_if.slave (handshakes, head entry, status)
module alu_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_result_stage_if.slave  bus
);

    // Head is what out_* shows; it is only overwritten by a new head, so after
    // the last pop it keeps the last popped entry.
    logic [WIDTH-1:0] head_result_q, head_result_d;
    logic [3:0]       head_flags_q, head_flags_d;
    logic [2:0]       head_cmd_q, head_cmd_d;
    logic [WIDTH-1:0] tail_result_q, tail_result_d;
    logic [3:0]       tail_flags_q, tail_flags_d;
    logic [2:0]       tail_cmd_q, tail_cmd_d;
    logic [1:0]       count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             sticky_carry_q, sticky_carry_d;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic             push, pop;
    logic [3:0]       new_flags;
    logic             new_neg;
    logic [CNT_W-1:0] ovf_base;

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && bus.out_ready;

    // Negative is only meaningful for add/sub results.
    assign new_neg   = (bus.in_command == 3'b000 || bus.in_command == 3'b001) ?
                       bus.in_result[WIDTH-1] : 1'b0;
    assign new_flags = {new_neg, bus.in_zero, bus.in_carryout, bus.in_overflow};

    always_comb begin
        head_result_d = head_result_q;
        head_flags_d  = head_flags_q;
        head_cmd_d    = head_cmd_q;
        tail_result_d = tail_result_q;
        tail_flags_d  = tail_flags_q;
        tail_cmd_d    = tail_cmd_q;
        count_d       = count_q;

        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_result_d = bus.in_result;
                    head_flags_d  = new_flags;
                    head_cmd_d    = bus.in_command;
                    count_d       = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_result_d = bus.in_result;
                    head_flags_d  = new_flags;
                    head_cmd_d    = bus.in_command;
                end else if (push) begin
                    tail_result_d = bus.in_result;
                    tail_flags_d  = new_flags;
                    tail_cmd_d    = bus.in_command;
                    count_d       = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen here.
                if (pop) begin
                    head_result_d = tail_result_q;
                    head_flags_d  = tail_flags_q;
                    head_cmd_d    = tail_cmd_q;
                    count_d       = 2'd1;
                end
            end
        endcase

        in_ready_d = (count_d != 2'(DEPTH));

        // Clear first, then apply the push so a same-cycle event is not lost.
        sticky_carry_d = (bus.sticky_clear ? 1'b0 : sticky_carry_q) | (push & bus.in_carryout);
        sticky_ovf_d   = (bus.sticky_clear ? 1'b0 : sticky_ovf_q) | (push & bus.in_overflow);

        ovf_base    = bus.sticky_clear ? '0 : ovf_count_q;
        ovf_count_d = ovf_base;
        if (push && bus.in_overflow && (ovf_base != {CNT_W{1'b1}})) begin
            ovf_count_d = ovf_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_result_q  <= '0;
            head_flags_q   <= '0;
            head_cmd_q     <= '0;
            tail_result_q  <= '0;
            tail_flags_q   <= '0;
            tail_cmd_q     <= '0;
            count_q        <= 2'd0;
            in_ready_q     <= 1'b1;
            sticky_carry_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
            ovf_count_q    <= '0;
        end else begin
            head_result_q  <= head_result_d;
            head_flags_q   <= head_flags_d;
            head_cmd_q     <= head_cmd_d;
            tail_result_q  <= tail_result_d;
            tail_flags_q   <= tail_flags_d;
            tail_cmd_q     <= tail_cmd_d;
            count_q        <= count_d;
            in_ready_q     <= in_ready_d;
            sticky_carry_q <= sticky_carry_d;
            sticky_ovf_q   <= sticky_ovf_d;
            ovf_count_q    <= ovf_count_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = (count_q != 2'd0);
    assign bus.out_result   = head_result_q;
    assign bus.out_flags    = head_flags_q;
    assign bus.out_command  = head_cmd_q;
    assign bus.sticky_carry = sticky_carry_q;
    assign bus.sticky_ovf   = sticky_ovf_q;
    assign bus.ovf_count    = ovf_count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed bench for alu_result_stage. A second instance
// with a 4-bit counter follows the same input traffic for the saturation case.
module tb_alu_result_stage;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_result_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();
    alu_result_stage_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

    alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    alu_result_stage #(.WIDTH(32), .DEPTH(2), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    assign bus4.in_valid     = bus.in_valid;
    assign bus4.in_result    = bus.in_result;
    assign bus4.in_carryout  = bus.in_carryout;
    assign bus4.in_zero      = bus.in_zero;
    assign bus4.in_overflow  = bus.in_overflow;
    assign bus4.in_command   = bus.in_command;
    assign bus4.out_ready    = bus.out_ready;
    assign bus4.sticky_clear = bus.sticky_clear;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [2:0] cmd,
                         input logic c, input logic z, input logic o);
        bus.in_valid    = v;
        bus.in_result   = res;
        bus.in_command  = cmd;
        bus.in_carryout = c;
        bus.in_zero     = z;
        bus.in_overflow = o;
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        rst_n            = 1'b0;
        bus.out_ready    = 1'b0;
        bus.sticky_clear = 1'b0;
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_result", 64'(bus.out_result), 64'd0);
        check("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check("rst_sticky", 64'({bus.sticky_carry, bus.sticky_ovf}), 64'd0);
        check("rst_ovf_count", 64'(bus.ovf_count), 64'd0);
        rst_n = 1'b1;

        // Single add push with negative result, carry and overflow
        drive(1'b1, 32'h8000_0000, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        check("single_valid", 64'(bus.out_valid), 64'd1);
        check("single_result", 64'(bus.out_result), 64'h8000_0000);
        check("single_flags", 64'(bus.out_flags), 64'b1011);
        check("single_cmd", 64'(bus.out_command), 64'd0);
        check("single_sticky_c", 64'(bus.sticky_carry), 64'd1);
        check("single_sticky_v", 64'(bus.sticky_ovf), 64'd1);
        check("single_ovf_count", 64'(bus.ovf_count), 64'd1);
        check("single_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("popped_valid", 64'(bus.out_valid), 64'd0);
        check("popped_hold", 64'(bus.out_result), 64'h8000_0000);

        // Streaming: 8 back-to-back pushes, non-add command masks N
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h8000_0100 + 32'(i), 3'b010, 1'b0, 1'b0, 1'b0);
            tick();
            check("stream_valid", 64'(bus.out_valid), 64'd1);
            check("stream_result", 64'(bus.out_result), 64'h8000_0100 + 64'(i));
            check("stream_flags", 64'(bus.out_flags), 64'd0);
            check("stream_in_ready", 64'(bus.in_ready), 64'd1);
        end
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        check("stream_drain", 64'(bus.out_valid), 64'd0);
        check("stream_last", 64'(bus.out_result), 64'h8000_0107);
        bus.out_ready = 1'b0;

        // Backpressure: 4 offered, 2 accepted, head stable
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'h8000_0200 + 32'(c), 3'b001, 1'b0, 1'b0, 1'b0);
            tick();
            check("bp_in_ready", 64'(bus.in_ready), (c == 0) ? 64'd1 : 64'd0);
            check("bp_head_stable", 64'(bus.out_result), 64'h8000_0200);
            check("bp_head_flags", 64'(bus.out_flags), 64'b1000);
        end
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_second", 64'(bus.out_result), 64'h8000_0201);
        check("bp_second_valid", 64'(bus.out_valid), 64'd1);
        check("bp_ready_back", 64'(bus.in_ready), 64'd1);
        tick();
        check("bp_empty", 64'(bus.out_valid), 64'd0);
        check("bp_no_dropped", 64'(bus.out_result), 64'h8000_0201);
        bus.out_ready = 1'b0;

        // SLT: N forced to 0, other flags pass through
        drive(1'b1, 32'h0000_0001, 3'b011, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        check("slt_flags", 64'(bus.out_flags), 64'b0110);
        check("slt_cmd", 64'(bus.out_command), 64'd3);
        bus.out_ready = 1'b1;
        tick();

        // Clear, then 5 overflow pushes, then clear racing an overflow push
        bus.sticky_clear = 1'b1;
        tick();
        bus.sticky_clear = 1'b0;
        check("clear_sticky", 64'({bus.sticky_carry, bus.sticky_ovf}), 64'd0);
        check("clear_count", 64'(bus.ovf_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(i), 3'b010, 1'b0, 1'b0, 1'b1);
            tick();
        end
        check("count5", 64'(bus.ovf_count), 64'd5);
        bus.sticky_clear = 1'b1;
        drive(1'b1, 32'h55, 3'b010, 1'b0, 1'b0, 1'b1);
        tick();
        bus.sticky_clear = 1'b0;
        check("race_count", 64'(bus.ovf_count), 64'd1);
        check("race_sticky_v", 64'(bus.sticky_ovf), 64'd1);
        check("race_sticky_c", 64'(bus.sticky_carry), 64'd0);

        // Saturation: 20 overflow pushes after a clear
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.sticky_clear = 1'b1;
        tick();
        bus.sticky_clear = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(i), 3'b010, 1'b0, 1'b0, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        tick();
        check("count20_w16", 64'(bus.ovf_count), 64'd20);
        check("sat_w4", 64'(bus4.ovf_count), 64'd15);

        // Mid-operation reset with 2 entries buffered
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b1, 32'hAAAA_0002, 3'b000, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0);
        check("pre_rst_full", 64'(bus.in_ready), 64'd0);
        check("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_count", 64'(bus.ovf_count), 64'd0);
        check("arst_sticky", 64'({bus.sticky_carry, bus.sticky_ovf}), 64'd0);
        check("arst_result", 64'(bus.out_result), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check("post_rst_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("post_rst_valid2", 64'(bus.out_valid), 64'd0);
        check("post_rst_result", 64'(bus.out_result), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
